// File: rtl/phase_pkg.sv
// phase_pkg: shared phase word width, phase word type and slew FSM states
// Contents: PHASE_W (phase word width), phase_t (one phase word), slew_state_t (IDLE, LOAD, SLEW)
package phase_pkg;
    localparam int PHASE_W = 32;
    typedef logic [PHASE_W-1:0] phase_t;
    typedef enum logic [1:0] {IDLE, LOAD, SLEW} slew_state_t;
endpackage

// File: rtl/phase_accumulator.sv
// phase_accumulator: registered NCO phase adder, phase <= phase + freq + add (mod 2^PHASE_W)
// Ports: clk, reset (sync, active-high), freq (increment per tick), add (extra slew increment), phase (accumulator)
module phase_accumulator
    import phase_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] freq,
    input  logic [PHASE_W-1:0] add,
    output logic [PHASE_W-1:0] phase
);
    phase_t phase_q, phase_d;

    always_comb phase_d = phase_q + freq + add;

    always_ff @(posedge clk) phase_q <= reset ? '0 : phase_d;

    assign phase = phase_q;
endmodule

// File: rtl/phase_slew_applier.sv
// phase_slew_applier: spreads a signed phase shift linearly over 2^slew_log2 ticks on a running NCO phase
// Ports: clk, reset (sync, active-high), start (apply phase_shift), freq (NCO increment, every cycle),
//        phase_shift (signed shift, sampled with start), slew_log2 (log2 slew ticks, sampled with start),
//        phase (NCO phase), busy (LOAD or SLEW), ready (last slew finished)
// Option: define PHASE_SLEW_RETRIGGER_EN to accept start during SLEW, folding the undelivered residue
//         into the new shift; otherwise start is ignored while busy.
module phase_slew_applier
    import phase_pkg::*;
#(
    parameter int SLEW_LOG2_MAX = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PHASE_W-1:0] freq,
    input  logic [PHASE_W-1:0] phase_shift,
    input  logic [4:0]         slew_log2,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               ready
);
    localparam logic [4:0] L_MAX = 5'(SLEW_LOG2_MAX);

    slew_state_t state_q, state_d;
    phase_t      shift_q, shift_d, step_q, step_d, rem_q, rem_d, count_q, count_d;
    phase_t      add, residue;
    logic [4:0]  l_q, l_d, l_in;
    logic        ready_q, ready_d, take;

    assign l_in = (slew_log2 > L_MAX) ? L_MAX : slew_log2;

`ifdef PHASE_SLEW_RETRIGGER_EN
    assign take    = start && (state_q == IDLE || state_q == SLEW);
    // this cycle's add is still delivered, so only the remaining count steps (and rem, if not yet paid) carry over
    assign residue = (state_q == SLEW && count_q != '0) ? count_q * step_q + rem_q : '0;
`else
    assign take    = start && state_q == IDLE;
    assign residue = '0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        l_d     = l_q;
        step_d  = step_q;
        rem_d   = rem_q;
        count_d = count_q;
        ready_d = ready_q;
        add     = '0;
        if (state_q == LOAD) begin
            step_d  = phase_t'($signed(shift_q) >>> l_q);
            rem_d   = shift_q - (step_d << l_q);
            count_d = (phase_t'(1) << l_q) - phase_t'(1);
            state_d = SLEW;
        end
        if (state_q == SLEW) begin
            add     = (count_q == '0) ? step_q + rem_q : step_q;
            count_d = count_q - phase_t'(1);
            state_d = (count_q == '0) ? IDLE : SLEW;
            ready_d = (count_q == '0) ? 1'b1 : ready_q;
        end
        if (take) begin
            shift_d = phase_shift + residue;
            l_d     = l_in;
            ready_d = 1'b0;
            state_d = LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            l_q     <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            l_q     <= l_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    phase_accumulator u_acc (
        .clk   (clk),
        .reset (reset),
        .freq  (freq),
        .add   (add),
        .phase (phase)
    );

    assign busy  = state_q != IDLE;
    assign ready = ready_q;
endmodule

// File: tb/tb_phase_slew_applier.sv
// tb_phase_slew_applier: directed self-checking bench for phase_slew_applier with SLEW_LOG2_MAX=4
module tb_phase_slew_applier;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] freq = '0;
    logic [31:0] phase_shift = '0;
    logic [4:0]  slew_log2 = '0;
    logic [31:0] phase;
    logic        busy, ready;
    int          n_cmp = 0;
    int          n_bad = 0;

    phase_slew_applier #(.SLEW_LOG2_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .freq        (freq),
        .phase_shift (phase_shift),
        .slew_log2   (slew_log2),
        .phase       (phase),
        .busy        (busy),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic kick(input logic [31:0] sh, input logic [4:0] l);
        start = 1'b1;
        phase_shift = sh;
        slew_log2 = l;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_phase", phase, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        reset = 1'b0;

        kick(32'h4000_0000, 5'd2);
        check("t1_load_busy", 32'(busy), 32'h1);
        tick();
        check("t1_n1_phase", phase, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t1_step%0d", k), phase, 32'(k) * 32'h1000_0000);
        end
        check("t1_ready", 32'(ready), 32'h1);
        check("t1_busy_done", 32'(busy), 32'h0);

        do_reset();
        kick(32'hC000_0001, 5'd4);
        tick(16);
        check("t2_after15", phase, 32'hC400_0000);
        check("t2_busy_last", 32'(busy), 32'h1);
        tick();
        check("t2_final", phase, 32'hC000_0001);
        check("t2_ready", 32'(ready), 32'h1);

        freq = 32'h0147_AE14;
        do_reset();
        kick(32'h0000_0008, 5'd3);
        tick(9);
        check("t3_n9", phase, 32'(10 * 32'h0147_AE14 + 8));
        tick();
        check("t3_n10", phase, 32'(11 * 32'h0147_AE14 + 8));
        freq = '0;

        do_reset();
        kick(32'h4000_0000, 5'd4);
        tick(5);
        check("t4_before_rst", phase, 32'h1000_0000);
        do_reset();
        check("t4_phase", phase, 32'h0);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_ready", 32'(ready), 32'h0);
        tick(3);
        check("t4_no_adds", phase, 32'h0);

        do_reset();
        kick(32'h0000_0100, 5'd3);
        tick(3);
        kick(32'h0000_0100, 5'd3);
        tick(30);
`ifdef PHASE_SLEW_RETRIGGER_EN
        check("t5_final", phase, 32'h0000_0200);
`else
        check("t5_final", phase, 32'h0000_0100);
`endif
        check("t5_ready", 32'(ready), 32'h1);

        do_reset();
        kick(32'h0000_0010, 5'd31);
        tick();
        check("t6_n1", phase, 32'h0);
        tick();
        check("t6_first", phase, 32'h1);
        tick(14);
        check("t6_15", phase, 32'hF);
        check("t6_busy", 32'(busy), 32'h1);
        tick();
        check("t6_final", phase, 32'h10);
        check("t6_ready", 32'(ready), 32'h1);

        do_reset();
        kick(32'h8000_0000, 5'd2);
        tick(2);
        check("neg180_first", phase, 32'hE000_0000);
        tick(3);
        check("neg180_final", phase, 32'h8000_0000);

        do_reset();
        kick(32'h1234_5678, 5'd0);
        check("l0_busy", 32'(busy), 32'h1);
        tick(2);
        check("l0_final", phase, 32'h1234_5678);
        check("l0_ready", 32'(ready), 32'h1);
        check("l0_idle", 32'(busy), 32'h0);

        kick(32'h0, 5'd1);
        check("zero_ready_clr", 32'(ready), 32'h0);
        tick(3);
        check("zero_phase", phase, 32'h1234_5678);
        check("zero_ready", 32'(ready), 32'h1);

        start = 1'b1;
        reset = 1'b1;
        phase_shift = 32'h100;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("rst_wins_busy", 32'(busy), 32'h0);
        tick(3);
        check("rst_wins_phase", phase, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
